ex_muldiv: RTL and testbench

Iterative multiply/divide unit in the EX stage of the 5-stage MIPS pipeline. Consumes operands and an operation code issued from the ID/EX boundary. Computes MULT/MULTU/DIV/DIVU over 32 cycles into the architectural HI/LO registers. Raises a stall toward IF/ID and ID/EX while an operation is in flight.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/ex_muldiv_if.sv | 25 ++
 rtl/ex_muldiv.sv | 127 ++++++++++++
 tb/tb_ex_muldiv.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the EX-stage multiply/divide unit:
// operation encodings, control states and the default iteration count.
package mips_pkg;

  localparam int MD_ITER = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE   = 2'b00,
    MD_RUN    = 2'b01,
    MD_FINISH = 2'b10
  } md_state_e;

  // Magnitude of a 32-bit operand; unsigned operands pass through untouched.
  function automatic logic [31:0] md_abs(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ID/EX-side request and HI/LO result signals of the multiply/divide unit.
// master = pipeline control issuing operations, slave = ex_muldiv.
interface ex_muldiv_if;
  logic        start_EX;
  logic [1:0]  op_EX;
  logic [31:0] rs_EX;
  logic [31:0] rt_EX;
  logic        mthi_EX;
  logic        mtlo_EX;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        done;

  modport master (
    output start_EX, op_EX, rs_EX, rt_EX, mthi_EX, mtlo_EX,
    input  hi, lo, busy, stall, done
  );

  modport slave (
    input  start_EX, op_EX, rs_EX, rt_EX, mthi_EX, mtlo_EX,
    output hi, lo, busy, stall, done
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one shift-add or restoring-divide step per
// cycle on magnitudes, sign correction in FINISH, results land in HI/LO.
module ex_muldiv
  import mips_pkg::*;
#(
  parameter int ITER = MD_ITER
) (
  input  logic        clk,
  input  logic        rst,
  ex_muldiv_if.slave  md
);

  localparam int CW = $clog2(ITER);

  md_state_e      r_state;
  logic [CW-1:0]  r_cnt;
  logic [63:0]    r_acc;
  logic [31:0]    r_opnd;
  logic           r_is_div;
  logic           r_neg_res;
  logic           r_neg_rem;
  logic           r_dz;
  logic [31:0]    r_hi;
  logic [31:0]    r_lo;
  logic           r_busy;
  logic           r_done;

  logic           w_is_div;
  logic           w_signed;
  logic [32:0]    w_mul_sum;
  logic [63:0]    w_mul_next;
  logic [33:0]    w_div_diff;
  logic [63:0]    w_div_next;
  logic [63:0]    w_prod;
  logic [31:0]    w_quot;
  logic [31:0]    w_rem;

  assign w_is_div = md.op_EX[1];
  assign w_signed = ~md.op_EX[0];

  // Multiply: r_acc = {partial product high, remaining multiplier bits}.
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
  assign w_mul_next = {w_mul_sum, r_acc[31:1]};

  // Divide: r_acc = {remainder, dividend bits shifting into quotient bits}.
  assign w_div_diff = {1'b0, r_acc[63:31]} - {2'b00, r_opnd};
  assign w_div_next = w_div_diff[33] ? {r_acc[62:0], 1'b0}
                                     : {w_div_diff[31:0], r_acc[30:0], 1'b1};

  assign w_prod = r_neg_res ? -r_acc : r_acc;
  assign w_quot = r_neg_res ? -r_acc[31:0]  : r_acc[31:0];
  assign w_rem  = r_neg_rem ? -r_acc[63:32] : r_acc[63:32];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= MD_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dz      <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        MD_IDLE: begin
          if (md.start_EX) begin
            r_is_div  <= w_is_div;
            r_neg_res <= w_signed & (md.rs_EX[31] ^ md.rt_EX[31]);
            r_neg_rem <= w_signed & w_is_div & md.rs_EX[31];
            r_opnd    <= md_abs(md.rt_EX, w_signed);
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            // Divide by zero skips iteration; raw dividend is kept for HI.
            if (w_is_div && (md.rt_EX == 32'd0)) begin
              r_dz    <= 1'b1;
              r_acc   <= {32'd0, md.rs_EX};
              r_state <= MD_FINISH;
            end else begin
              r_dz    <= 1'b0;
              r_acc   <= {32'd0, md_abs(md.rs_EX, w_signed)};
              r_state <= MD_RUN;
            end
          end else begin
            if (md.mthi_EX) r_hi <= md.rs_EX;
            if (md.mtlo_EX) r_lo <= md.rs_EX;
          end
        end
        MD_RUN: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          if (r_cnt == CW'(ITER - 1)) begin
            r_state <= MD_FINISH;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        MD_FINISH: begin
          if (r_dz) begin
            r_hi <= r_acc[31:0];
            r_lo <= 32'hFFFF_FFFF;
          end else if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end else begin
            {r_hi, r_lo} <= w_prod;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= MD_IDLE;
        end
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  assign md.hi    = r_hi;
  assign md.lo    = r_lo;
  assign md.busy  = r_busy;
  assign md.stall = r_busy;
  assign md.done  = r_done;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv: reset, moves, multiply/divide
// results, latency, ignored restart, divide by zero and mid-operation reset.
module tb_ex_muldiv;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  ex_muldiv_if bus ();

  ex_muldiv dut (
    .clk (clk),
    .rst (rst),
    .md  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.start_EX = 1'b0;
    bus.op_EX    = 2'b00;
    bus.rs_EX    = 32'd0;
    bus.rt_EX    = 32'd0;
    bus.mthi_EX  = 1'b0;
    bus.mtlo_EX  = 1'b0;
  endtask

  // Issue one operation and follow it to its done pulse. exp_lat is the number
  // of edges after the start edge at which done is first seen high; busy must
  // be high for exactly that many samples. inj >= 0 re-pulses start at that
  // cycle, which must be ignored. mv also asserts mthi/mtlo with start.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int exp_lat, input int inj, input bit mv,
                        input logic [31:0] prev_hi);
    int lat;
    int busy_cnt;
    bit stall_ok;
    bus.start_EX = 1'b1;
    bus.op_EX    = op;
    bus.rs_EX    = a;
    bus.rt_EX    = b;
    bus.mthi_EX  = mv;
    bus.mtlo_EX  = mv;
    @(posedge clk);
    #1;
    drive_idle();
    lat      = -1;
    busy_cnt = 0;
    stall_ok = 1'b1;
    if (mv) chk({tag, " hi held"}, {32'd0, bus.hi}, {32'd0, prev_hi});
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.stall !== bus.busy) stall_ok = 1'b0;
      if (bus.done === 1'b1) begin
        lat = cyc;
        break;
      end
      if (cyc == inj) begin
        bus.start_EX = 1'b1;
        bus.op_EX    = 2'b11;
        bus.rs_EX    = 32'd1;
        bus.rt_EX    = 32'd1;
      end
      @(posedge clk);
      #1;
      drive_idle();
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_lat));
    chk({tag, " stall==busy"}, {63'd0, stall_ok}, 64'd1);
    chk({tag, " hi"}, {32'd0, bus.hi}, {32'd0, exp_hi});
    chk({tag, " lo"}, {32'd0, bus.lo}, {32'd0, exp_lo});
    @(posedge clk);
    #1;
    chk({tag, " done single"}, {63'd0, bus.done}, 64'd0);
    $display("op %-14s a=%h b=%h -> hi=%h lo=%h lat=%0d busy=%0d",
             tag, a, b, bus.hi, bus.lo, lat, busy_cnt);
  endtask

  initial begin
    int done_cnt;
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("reset hi",    {32'd0, bus.hi}, 64'd0);
    chk("reset lo",    {32'd0, bus.lo}, 64'd0);
    chk("reset busy",  {63'd0, bus.busy}, 64'd0);
    chk("reset stall", {63'd0, bus.stall}, 64'd0);
    chk("reset done",  {63'd0, bus.done}, 64'd0);
    $display("reset  hi=%h lo=%h busy=%b", bus.hi, bus.lo, bus.busy);
    rst = 1'b0;

    bus.mthi_EX = 1'b1;
    bus.rs_EX   = 32'h0000_1234;
    @(posedge clk);
    #1;
    drive_idle();
    chk("mthi hi",   {32'd0, bus.hi}, 64'h1234);
    chk("mthi lo",   {32'd0, bus.lo}, 64'd0);
    chk("mthi done", {63'd0, bus.done}, 64'd0);
    $display("mthi   rs=00001234 -> hi=%h lo=%h", bus.hi, bus.lo);

    bus.mthi_EX = 1'b1;
    bus.mtlo_EX = 1'b1;
    bus.rs_EX   = 32'h0000_0055;
    @(posedge clk);
    #1;
    drive_idle();
    chk("mthi+mtlo hi", {32'd0, bus.hi}, 64'h55);
    chk("mthi+mtlo lo", {32'd0, bus.lo}, 64'h55);
    chk("mthi+mtlo busy", {63'd0, bus.busy}, 64'd0);
    $display("mthilo rs=00000055 -> hi=%h lo=%h", bus.hi, bus.lo);

    run_op("multu+move", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 33, -1, 1'b1, 32'h55);
    run_op("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h0000_0001, 33, -1, 1'b0, 32'd0);
    run_op("mult -3*7", 2'b00, 32'hFFFF_FFFD, 32'd7,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, -1, 1'b0, 32'd0);
    run_op("mult -5*-6", 2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFA,
           32'd0, 32'd30, 33, -1, 1'b0, 32'd0);
    run_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, -1, 1'b0, 32'd0);
    run_op("div min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
           32'd0, 32'h8000_0000, 33, -1, 1'b0, 32'd0);
    run_op("divu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 33, -1, 1'b0, 32'd0);
    run_op("multu restart", 2'b01, 32'd10, 32'd10, 32'd0, 32'd100, 33, 5, 1'b0, 32'd0);
    run_op("divu 5/0", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1, -1, 1'b0, 32'd0);

    // Reset in the middle of an operation discards it.
    bus.start_EX = 1'b1;
    bus.op_EX    = 2'b01;
    bus.rs_EX    = 32'd3;
    bus.rt_EX    = 32'd4;
    @(posedge clk);
    #1;
    drive_idle();
    repeat (9) @(posedge clk);
    #1;
    chk("pre-reset busy", {63'd0, bus.busy}, 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid-reset hi",   {32'd0, bus.hi}, 64'd0);
    chk("mid-reset lo",   {32'd0, bus.lo}, 64'd0);
    chk("mid-reset busy", {63'd0, bus.busy}, 64'd0);
    chk("mid-reset done", {63'd0, bus.done}, 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) done_cnt++;
    end
    chk("mid-reset no done", 64'(done_cnt), 64'd0);
    chk("mid-reset idle", {63'd0, bus.busy}, 64'd0);
    $display("reset mid-run -> hi=%h lo=%h busy=%b done_pulses=%0d",
             bus.hi, bus.lo, bus.busy, done_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
